// File: rtl/mdu_unit.sv
// Multiply/divide unit for the E stage. It owns the HI/LO registers,
// runs mult/multu/div/divu with a fixed busy period, and serves
// mfhi/mflo/mthi/mtlo.
module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_en,
    input  logic [3:0]  MDU_type,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        start,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDU_result
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic [31:0]        hi_reg, hi_next;
    logic [31:0]        lo_reg, lo_next;
    logic [31:0]        temp_hi_reg, temp_hi_next;
    logic [31:0]        temp_lo_reg, temp_lo_next;
    logic               div_zero_reg, div_zero_next;

    // Arithmetic datapath, evaluated from the operands in the issue cycle.
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] b_safe;
    logic [31:0] a_mag, b_mag, b_mag_safe;
    logic [31:0] quot_u, rem_u, quot_m, rem_m, quot_s, rem_s;

    // Multipliers and dividers. Signed division works on magnitudes so the
    // 0x80000000 / -1 case falls out naturally (quotient 0x80000000, rem 0).
    // A zero divisor is replaced by 1 only to keep the dividers defined;
    // the result is discarded at commit in that case.
    always_comb begin
        prod_s     = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        prod_u     = {32'd0, a} * {32'd0, b};
        b_safe     = (b == 32'd0) ? 32'd1 : b;
        a_mag      = a[31] ? (32'd0 - a) : a;
        b_mag      = b[31] ? (32'd0 - b) : b;
        b_mag_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
        quot_u     = a / b_safe;
        rem_u      = a % b_safe;
        quot_m     = a_mag / b_mag_safe;
        rem_m      = a_mag % b_mag_safe;
        quot_s     = (a[31] ^ b[31]) ? (32'd0 - quot_m) : quot_m;
        rem_s      = a[31] ? (32'd0 - rem_m) : rem_m;
    end

    assign busy  = (state_reg == ST_BUSY);
    assign start = req_en && !busy && (MDU_type >= OP_MULT) && (MDU_type <= OP_DIVU);
    assign HI    = hi_reg;
    assign LO    = lo_reg;

    // Read port for mfhi/mflo; zero for every other command.
    always_comb begin
        MDU_result = 32'd0;
        if (req_en && MDU_type == OP_MFHI)
            MDU_result = hi_reg;
        else if (req_en && MDU_type == OP_MFLO)
            MDU_result = lo_reg;
    end

    // Next-state logic: issue, countdown/commit, and HI/LO moves.
    always_comb begin
        state_next    = state_reg;
        count_next    = count_reg;
        hi_next       = hi_reg;
        lo_next       = lo_reg;
        temp_hi_next  = temp_hi_reg;
        temp_lo_next  = temp_lo_reg;
        div_zero_next = div_zero_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next    = ST_BUSY;
                    div_zero_next = 1'b0;
                    case (MDU_type)
                        OP_MULT: begin
                            temp_hi_next = prod_s[63:32];
                            temp_lo_next = prod_s[31:0];
                            count_next   = CNT_W'(MULT_CYCLES);
                        end
                        OP_MULTU: begin
                            temp_hi_next = prod_u[63:32];
                            temp_lo_next = prod_u[31:0];
                            count_next   = CNT_W'(MULT_CYCLES);
                        end
                        OP_DIV: begin
                            temp_hi_next  = rem_s;
                            temp_lo_next  = quot_s;
                            div_zero_next = (b == 32'd0);
                            count_next    = CNT_W'(DIV_CYCLES);
                        end
                        default: begin
                            temp_hi_next  = rem_u;
                            temp_lo_next  = quot_u;
                            div_zero_next = (b == 32'd0);
                            count_next    = CNT_W'(DIV_CYCLES);
                        end
                    endcase
                end else if (req_en && MDU_type == OP_MTHI) begin
                    hi_next = a;
                end else if (req_en && MDU_type == OP_MTLO) begin
                    lo_next = a;
                end
            end
            default: begin
                if (count_reg == CNT_W'(1)) begin
                    state_next = ST_IDLE;
                    count_next = '0;
                    if (!div_zero_reg) begin
                        hi_next = temp_hi_reg;
                        lo_next = temp_lo_reg;
                    end
                end else begin
                    count_next = count_reg - CNT_W'(1);
                end
            end
        endcase
    end

    // State registers; reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            count_reg    <= '0;
            hi_reg       <= 32'd0;
            lo_reg       <= 32'd0;
            temp_hi_reg  <= 32'd0;
            temp_lo_reg  <= 32'd0;
            div_zero_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            hi_reg       <= hi_next;
            lo_reg       <= lo_next;
            temp_hi_reg  <= temp_hi_next;
            temp_lo_reg  <= temp_lo_next;
            div_zero_reg <= div_zero_next;
        end
    end

endmodule

// File: tb/tb_mdu_unit.sv
// Directed testbench for mdu_unit: one task per scenario, inline checks.
module tb_mdu_unit;

    logic        clk;
    logic        reset;
    logic        req_en;
    logic [3:0]  MDU_type;
    logic [31:0] a;
    logic [31:0] b;
    logic        start;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDU_result;

    int errors = 0;
    int checks = 0;

    mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .req_en(req_en), .MDU_type(MDU_type),
        .a(a), .b(b), .start(start), .busy(busy), .HI(HI), .LO(LO),
        .MDU_result(MDU_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; inputs change 1ns after it, outputs are read before the next one.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input logic en, input logic [3:0] t, input logic [31:0] av, input logic [31:0] bv);
        req_en = en; MDU_type = t; a = av; b = bv;
        #1;
    endtask

    // Present a command for one edge, then return to idle inputs.
    task automatic issue(input logic [3:0] t, input logic [31:0] av, input logic [31:0] bv, output logic start_seen);
        set_cmd(1'b1, t, av, bv);
        start_seen = start;
        tick();
        set_cmd(1'b0, 4'd0, 32'd0, 32'd0);
    endtask

    // Count cycles until busy drops, bounded.
    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (busy && cycles < 40) begin
            tick();
            cycles++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_cmd(1'b0, 4'd0, 32'd0, 32'd0);
        tick(); tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({busy, start, HI, LO, MDU_result} !== {1'b0, 1'b0, 96'd0}) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d busy=%b start=%b HI=%h LO=%h res=%h required 0", i, busy, start, HI, LO, MDU_result);
            end
            tick();
        end
        set_cmd(1'b0, 4'd1, 32'd5, 32'd7);
        checks++;
        if (start !== 1'b0) begin
            errors++;
            $display("FAIL gated_start got=%b required=0", start);
        end
        tick();
        checks++;
        if ({busy, HI, LO} !== {1'b0, 64'd0}) begin
            errors++;
            $display("FAIL gated_state busy=%b HI=%h LO=%h required 0", busy, HI, LO);
        end
        set_cmd(1'b0, 4'd0, 32'd0, 32'd0);
        $display("test_reset done");
    endtask

    // Issue one long operation and check start, busy length, and result.
    task automatic run_and_check(input string name, input logic [3:0] t, input logic [31:0] av, input logic [31:0] bv,
                                 input int exp_cycles, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        logic s;
        int   cyc;
        issue(t, av, bv, s);
        checks++;
        if (s !== 1'b1 || start !== 1'b0) begin
            errors++;
            $display("FAIL %s_start issue=%b after=%b required 1/0", name, s, start);
        end
        wait_idle(cyc);
        checks++;
        if (cyc != exp_cycles) begin
            errors++;
            $display("FAIL %s_busy cycles=%0d required=%0d", name, cyc, exp_cycles);
        end
        checks++;
        if (HI !== exp_hi || LO !== exp_lo) begin
            errors++;
            $display("FAIL %s_result HI=%h LO=%h required HI=%h LO=%h", name, HI, LO, exp_hi, exp_lo);
        end
        $display("%s a=%h b=%h busy=%0d HI=%h LO=%h", name, av, bv, cyc, HI, LO);
    endtask

    task automatic test_mult();
        run_and_check("mult",  4'd1, 32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA);
        run_and_check("multu", 4'd2, 32'hFFFFFFFE, 32'd3, 5, 32'h00000002, 32'hFFFFFFFA);
    endtask

    task automatic test_div();
        logic s;
        run_and_check("div",  4'd3, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_and_check("divu", 4'd4, 32'd7, 32'd2, 10, 32'd1, 32'd3);
        issue(4'd7, 32'h11, 32'd0, s);
        issue(4'd8, 32'h22, 32'd0, s);
        run_and_check("div_by_zero", 4'd3, 32'd5, 32'd0, 10, 32'h11, 32'h22);
        run_and_check("div_ovf", 4'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'd0, 32'h80000000);
    endtask

    task automatic test_move();
        logic s;
        issue(4'd7, 32'h12345678, 32'd0, s);
        checks++;
        if (s !== 1'b0 || busy !== 1'b0 || HI !== 32'h12345678) begin
            errors++;
            $display("FAIL mthi start=%b busy=%b HI=%h required 0/0/12345678", s, busy, HI);
        end
        set_cmd(1'b1, 4'd6, 32'd0, 32'd0);
        checks++;
        if (MDU_result !== 32'h80000000 || LO !== 32'h80000000) begin
            errors++;
            $display("FAIL mflo res=%h LO=%h required 80000000", MDU_result, LO);
        end
        tick();
        set_cmd(1'b1, 4'd5, 32'd0, 32'd0);
        checks++;
        if (MDU_result !== 32'h12345678 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mfhi res=%h busy=%b required 12345678/0", MDU_result, busy);
        end
        tick();
        set_cmd(1'b0, 4'd0, 32'd0, 32'd0);
        $display("move HI=%h LO=%h", HI, LO);
    endtask

    task automatic test_busy_ignore();
        logic s;
        int   cyc;
        issue(4'd1, 32'hFFFFFFFE, 32'd3, s);
        tick();                                   // now in busy cycle 2
        set_cmd(1'b1, 4'd8, 32'h0000DEAD, 32'd0);
        checks++;
        if (start !== 1'b0) begin
            errors++;
            $display("FAIL ignore_mtlo_start got=%b required=0", start);
        end
        tick();
        set_cmd(1'b1, 4'd1, 32'd5, 32'd5);
        checks++;
        if (start !== 1'b0) begin
            errors++;
            $display("FAIL ignore_mult_start got=%b required=0", start);
        end
        tick();
        set_cmd(1'b0, 4'd0, 32'd0, 32'd0);
        wait_idle(cyc);
        cyc = cyc + 3;
        checks++;
        if (cyc != 5 || HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFA) begin
            errors++;
            $display("FAIL ignore_result cycles=%0d HI=%h LO=%h required 5 FFFFFFFF FFFFFFFA", cyc, HI, LO);
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL ignore_no_reissue busy=%b required=0", busy);
        end
        $display("busy_ignore busy=%0d HI=%h LO=%h", cyc, HI, LO);
    endtask

    task automatic test_reset_mid();
        logic s;
        issue(4'd7, 32'h55, 32'd0, s);
        issue(4'd8, 32'h66, 32'd0, s);
        issue(4'd3, 32'd100, 32'd7, s);          // busy cycle 1
        tick();                                   // busy cycle 2
        tick();                                   // busy cycle 3
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({busy, HI, LO} !== {1'b0, 64'd0}) begin
            errors++;
            $display("FAIL reset_mid busy=%b HI=%h LO=%h required 0", busy, HI, LO);
        end
        $display("reset_mid busy=%b HI=%h LO=%h", busy, HI, LO);
        run_and_check("mult_after_reset", 4'd1, 32'd7, 32'd6, 5, 32'd0, 32'd42);
    endtask

    initial begin
        reset = 1'b1;
        req_en = 1'b0; MDU_type = 4'd0; a = 32'd0; b = 32'd0;
        #2;
        test_reset();
        test_mult();
        test_div();
        test_move();
        test_busy_ignore();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- E-stage multiply/divide unit of the pipelined MIPS core.
- Responder for the 4-bit MDU_type command issued by the control unit.
- Executes mult/multu/div/divu over several cycles and owns the HI/LO registers.
- Serves mfhi/mflo reads, accepts mthi/mtlo writes, and drives start/busy for the hazard unit's D-stage stall logic.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (>=1)
- DIV_CYCLES, 10, busy cycles for div/divu (>=1)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high; clears all state
- req_en  in  1  E-stage instruction valid (0 for bubble); gates all commands
- MDU_type  in  4  command: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9-15 none
- a  in  32  forwarded rs value
- b  in  32  forwarded rt value
- start  out  1  combinational; req_en & MDU_type in 1..4 & !busy
- busy  out  1  registered; high while an operation is in flight
- HI  out  32  HI register
- LO  out  32  LO register
- MDU_result  out  32  combinational; HI when mfhi, LO when mflo, else 0

Behaviour:
- Interface fact: one clock; reset is synchronous and active-high (ports clk, reset).
- Reset: HI=0, LO=0, busy=0, counter=0, temp registers=0. Reset mid-operation abandons the operation; HI/LO stay 0.
- Issue (start=1 at edge):
  - mult: temp = $signed(a)*$signed(b), 64-bit.
  - multu: temp = a*b, unsigned, 64-bit.
  - div: tempLO = signed quotient, tempHI = signed remainder, truncated toward zero, remainder takes the dividend's sign.
  - divu: unsigned quotient/remainder.
  - Counter loads MULT_CYCLES or DIV_CYCLES; busy=1 from the next cycle.
- Busy state: counter decrements each edge. On the edge where counter==1: HI<=temp[63:32] (or remainder), LO<=temp[31:0] (or quotient), busy<=0, counter<=0.
- Total latency: the issue edge plus N busy cycles; new HI/LO is visible in the cycle busy first reads 0.
- Divide by zero (div/divu with b==0): full busy period still runs; HI/LO left unchanged at commit.
- div of 0x80000000 by 0xFFFFFFFF: LO=0x80000000, HI=0.
- mthi/mtlo with req_en & !busy: HI<=a (or LO<=a) at the next edge; busy stays 0.
- mfhi/mflo: MDU_result reflects the current HI/LO combinationally; no state change.
- Commands arriving while busy (1..8): ignored, no state change, start=0. The hazard unit must stall D on (start|busy) & (md|mt|mf); this block does not rely on it for safety.
- req_en=0 or MDU_type 0/9-15: no effect.
- start is asserted only in the issue cycle. busy never overlaps the issue cycle. No back-to-back issue until busy=0.
- The counter is wide enough for max(MULT_CYCLES, DIV_CYCLES). No wrap-around; the counter saturates at 0 when idle.

Test Plan:
- Reset then idle: HI=LO=0, busy=0, start=0, MDU_result=0 for 3 cycles; req_en=0 with MDU_type=1 leaves all unchanged.
- mult a=0xFFFFFFFE (-2), b=3 -> start=1 one cycle; busy=1 exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. Same operands with multu -> HI=0x00000002, LO=0xFFFFFFFA.
- div a=-7 (0xFFFFFFF9), b=2 -> busy 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu a=7, b=2 -> LO=3, HI=1. div by b=0 after mthi 0x11/mtlo 0x22 -> HI=0x11, LO=0x22 after 10 busy cycles.
- mthi a=0x12345678 then mflo/mfhi next cycles -> MDU_result=0x12345678 on mfhi; LO unchanged on mflo; busy never asserts.
- While busy from mult, issue mtlo 0xDEAD and a second mult -> both ignored, start=0; final HI/LO equal the first mult result; commit stays on cycle 5.
- reset asserted in busy cycle 3 of a div -> next cycle busy=0, HI=LO=0; the following mult completes normally in 5 cycles.
